gpio_input_debounce: RTL

- Conditions raw board inputs (switches, keys, GPIO_0 header pins) before they reach the SoC `gpio0_i` bus.
- Per bit, it synchronises the asynchronous pad into the `clock` domain and debounces it with a stability counter.
- It emits one-cycle rise/fall strobes.
- Sits in the board top between the pads and `picorv32_wb_soc`, clocked by the clkgen `wb_clk` output.

---
 rtl/gpio_debounce_pkg.sv | 25 ++
 rtl/gpio_debounce_bit.sv | 69 ++++++
 rtl/gpio_input_debounce.sv | 79 +++++++
 3 files changed

// File: rtl/gpio_debounce_pkg.sv
// Shared helpers for the GPIO input debouncer: width and window-length
// arithmetic plus the legal synchroniser depth range.
package gpio_debounce_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int debounce_cycles(input int clk_freq_hz, input int debounce_us);
        return (clk_freq_hz / 1000000) * debounce_us;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input bit: pad synchroniser, stability counter, debounced level and
// registered rise/fall strobes.
module gpio_debounce_bit
    import gpio_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 3,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic update
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
            $error("gpio_debounce_bit: SYNC_STAGES out of range");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync;
    logic                   differ;
    logic                   at_max;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign differ = sync ^ level;
    assign at_max = (cnt == CNT_MAX);
    // Combinational view of this edge's level change, used by the top for changed_o.
    assign update = differ & at_max;

    // Plain flop chain: nothing may sit between metastability stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= RESET_VALUE;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= update & sync;
            fall <= update & ~sync;
            if (!differ) begin
                cnt <= '0;
            end else if (at_max) begin
                cnt   <= '0;
                level <= sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input_debounce.sv
// Board-input conditioner: per-bit synchronise + debounce with rise/fall strobes.
// Optional pending/IRQ logic is built when GPIO_INPUT_DEBOUNCE_IRQ_EN is defined.
module gpio_input_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CLK_FREQ_HZ = 24000000,
    parameter int               DEBOUNCE_US = 5000,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
`ifdef GPIO_INPUT_DEBOUNCE_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_clear_i,
    output logic [WIDTH-1:0] irq_pending_o,
    output logic             irq_o
`endif
);

    localparam int DEBOUNCE_CYCLES = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_US);
    localparam int CNT_W           = clog2(DEBOUNCE_CYCLES + 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_window
            $error("gpio_input_debounce: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] update;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_bit (
            .clock   (clock),
            .reset_n (reset_n),
            .pin     (pins_i[i]),
            .level   (gpio_o[i]),
            .rise    (rise_o[i]),
            .fall    (fall_o[i]),
            .update  (update[i])
        );
    end

    // Registered from the same update terms as the strobes so it pulses with them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            changed_o <= 1'b0;
        end else begin
            changed_o <= |update;
        end
    end

`ifdef GPIO_INPUT_DEBOUNCE_IRQ_EN
    // A strobe outranks a clear landing on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending_o <= '0;
            irq_o         <= 1'b0;
        end else begin
            irq_pending_o <= (irq_pending_o & ~irq_clear_i) | rise_o | fall_o;
            irq_o         <= |irq_pending_o;
        end
    end
`else
    // Interrupt support not built: no pending state.
`endif

endmodule
